zt_des_cuckoo_arb: RTL and testbench

Front-end arbiter and scheduler for the single-search / single-update cuckoo hash table port pair.
- Shares the table's one search port among NUMSREQ requesters and its one update port among NUMUREQ requesters, both round-robin.
- Routes each search response back to the requester that issued it.
- Enforces a search-burst limit with drain slots, so that a continuous search stream cannot starve the table's internal update FIFO.

---
 rtl/zt_des_cuckoo_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_zt_des_cuckoo_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/zt_des_cuckoo_arb.sv
// Round-robin search/update arbiter for a cuckoo hash table, with search-burst drain slots and response routing.
// Optional statistics counters are enabled by defining ZT_CUCKOO_ARB_STATS_EN.
module zt_des_cuckoo_arb #(
    parameter int NUMSREQ  = 4,
    parameter int NUMUREQ  = 2,
    parameter int KYWIDTH  = 5,
    parameter int DTWIDTH  = 1,
    parameter int SR_LAT   = 1,
    parameter int SRBURST  = 8,
    parameter int DRAINCYC = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMSREQ-1:0]         sreq,
    input  logic [NUMSREQ*KYWIDTH-1:0] skey,
    output logic [NUMSREQ-1:0]         sgnt,
    output logic [NUMSREQ-1:0]         srsp_vld,
    output logic                       srsp_hit,
    output logic [DTWIDTH-1:0]         srsp_dout,
    input  logic [NUMUREQ-1:0]         ureq,
    input  logic [NUMUREQ*KYWIDTH-1:0] ukey,
    input  logic [NUMUREQ*DTWIDTH-1:0] udin,
    input  logic [NUMUREQ-1:0]         udel,
    output logic [NUMUREQ-1:0]         ugnt,
    output logic                       search_0,
    output logic [KYWIDTH-1:0]         sr_key_0,
    input  logic                       sr_vld_0,
    input  logic                       sr_hit_0,
    input  logic [DTWIDTH-1:0]         sr_dout_0,
    output logic                       update_1,
    output logic [KYWIDTH-1:0]         up_key_1,
    output logic [DTWIDTH-1:0]         up_din_1,
    output logic                       up_del_1,
    input  logic                       up_bp_1,
`ifdef ZT_CUCKOO_ARB_STATS_EN
    output logic [31:0]                st_srch,
    output logic [31:0]                st_upd,
    output logic [31:0]                st_bp,
`endif
    output logic                       err
);

    localparam int SPW = (NUMSREQ > 1) ? $clog2(NUMSREQ) : 1;
    localparam int UPW = (NUMUREQ > 1) ? $clog2(NUMUREQ) : 1;
    localparam int BW  = $clog2(SRBURST + 1);
    localparam int DCW = $clog2(DRAINCYC + 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(SRBURST - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAINCYC - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                burst_q, burst_d;
    logic [DCW-1:0]               drain_q, drain_d;
    logic [SPW-1:0]               sptr_q, sptr_d;
    logic [UPW-1:0]               uptr_q, uptr_d;
    logic                         init_q, err_q, err_d;
    logic [SR_LAT-1:0]            tag_vld_q, tag_vld_d;
    logic [SR_LAT-1:0][SPW-1:0]   tag_id_q, tag_id_d;

    logic [SPW-1:0] s_idx, s_win;
    logic [UPW-1:0] u_idx, u_win;
    logic           s_found, u_found, s_issue, u_issue;
    logic           rsp_vld;
    logic [SPW-1:0] rsp_id;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        s_idx   = '0;
        s_win   = '0;
        s_found = 1'b0;
        for (int i = 0; i < NUMSREQ; i++) begin
            s_idx = SPW'((int'(sptr_q) + i) % NUMSREQ);
            if (!s_found && sreq[s_idx]) begin
                s_found = 1'b1;
                s_win   = s_idx;
            end
        end
        u_idx   = '0;
        u_win   = '0;
        u_found = 1'b0;
        for (int i = 0; i < NUMUREQ; i++) begin
            u_idx = UPW'((int'(uptr_q) + i) % NUMUREQ);
            if (!u_found && ureq[u_idx]) begin
                u_found = 1'b1;
                u_win   = u_idx;
            end
        end
    end

    // init_q keeps every output quiet during the first cycle after reset release.
    assign s_issue = s_found & ready & init_q & (state_q == ST_RUN);
    assign u_issue = u_found & ready & init_q & ~up_bp_1;

    always_comb begin
        sgnt     = '0;
        search_0 = s_issue;
        sr_key_0 = '0;
        sptr_d   = sptr_q;
        if (s_issue) begin
            sgnt[s_win] = 1'b1;
            sr_key_0    = skey[int'(s_win)*KYWIDTH +: KYWIDTH];
            sptr_d      = (s_win == SPW'(NUMSREQ - 1)) ? '0 : s_win + 1'b1;
        end
        ugnt     = '0;
        update_1 = u_issue;
        up_key_1 = '0;
        up_din_1 = '0;
        up_del_1 = 1'b0;
        uptr_d   = uptr_q;
        if (u_issue) begin
            ugnt[u_win] = 1'b1;
            up_key_1    = ukey[int'(u_win)*KYWIDTH +: KYWIDTH];
            up_din_1    = udin[int'(u_win)*DTWIDTH +: DTWIDTH];
            up_del_1    = udel[u_win];
            uptr_d      = (u_win == UPW'(NUMUREQ - 1)) ? '0 : u_win + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        drain_d = drain_q;
        if (ready && init_q) begin
            case (state_q)
                ST_RUN: begin
                    if (!s_issue) begin
                        burst_d = '0;
                    end else if (burst_q == BURST_LAST) begin
                        state_d = ST_DRAIN;
                        burst_d = '0;
                        drain_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
                default: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_RUN;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Tag pipeline mirrors the table's fixed search latency.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = s_issue;
        tag_id_d[0]  = s_win;
        for (int i = 1; i < SR_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    assign rsp_vld = tag_vld_q[SR_LAT-1];
    assign rsp_id  = tag_id_q[SR_LAT-1];

    always_comb begin
        srsp_vld = '0;
        if (rsp_vld) srsp_vld[rsp_id] = sr_vld_0;
        srsp_hit  = rsp_vld & sr_hit_0;
        srsp_dout = rsp_vld ? sr_dout_0 : '0;
        err_d     = err_q | (sr_vld_0 & ~rsp_vld) | (rsp_vld & ~sr_vld_0);
    end

    assign err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            burst_q   <= '0;
            drain_q   <= '0;
            sptr_q    <= '0;
            uptr_q    <= '0;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            drain_q   <= drain_d;
            sptr_q    <= sptr_d;
            uptr_q    <= uptr_d;
            init_q    <= 1'b1;
            err_q     <= err_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

`ifdef ZT_CUCKOO_ARB_STATS_EN
    logic [31:0] st_srch_q, st_srch_d, st_upd_q, st_upd_d, st_bp_q, st_bp_d;

    always_comb begin
        st_srch_d = st_srch_q + 32'(s_issue);
        st_upd_d  = st_upd_q + 32'(u_issue);
        st_bp_d   = st_bp_q + 32'((|ureq) & up_bp_1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_srch_q <= '0;
            st_upd_q  <= '0;
            st_bp_q   <= '0;
        end else begin
            st_srch_q <= st_srch_d;
            st_upd_q  <= st_upd_d;
            st_bp_q   <= st_bp_d;
        end
    end

    assign st_srch = st_srch_q;
    assign st_upd  = st_upd_q;
    assign st_bp   = st_bp_q;
`endif

endmodule

// File: tb/tb_zt_des_cuckoo_arb.sv
// Directed bench for zt_des_cuckoo_arb: grant sequences, drain slots, response routing, err and reset behaviour.
// Statistics outputs are checked when ZT_CUCKOO_ARB_STATS_EN is defined.
module tb_zt_des_cuckoo_arb;
    localparam int NS = 4;
    localparam int NU = 2;
    localparam int KW = 5;
    localparam int DW = 1;
    localparam int W  = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready = 1'b0;
    logic [NS-1:0] sreq = '0;
    logic [NS*KW-1:0] skey = '0;
    logic [NS-1:0] sgnt, srsp_vld;
    logic srsp_hit;
    logic [DW-1:0] srsp_dout;
    logic [NU-1:0] ureq = '0;
    logic [NU*KW-1:0] ukey = '0;
    logic [NU*DW-1:0] udin = '0;
    logic [NU-1:0] udel = '0;
    logic [NU-1:0] ugnt;
    logic search_0, update_1, up_del_1, err;
    logic [KW-1:0] sr_key_0, up_key_1;
    logic [DW-1:0] up_din_1;
    logic sr_vld_0, sr_hit_0;
    logic [DW-1:0] sr_dout_0;
    logic up_bp_1 = 1'b0;
`ifdef ZT_CUCKOO_ARB_STATS_EN
    logic [31:0] st_srch, st_upd, st_bp;
`endif

    zt_des_cuckoo_arb dut (
        .clk(clk), .rst(rst), .ready(ready),
        .sreq(sreq), .skey(skey), .sgnt(sgnt),
        .srsp_vld(srsp_vld), .srsp_hit(srsp_hit), .srsp_dout(srsp_dout),
        .ureq(ureq), .ukey(ukey), .udin(udin), .udel(udel), .ugnt(ugnt),
        .search_0(search_0), .sr_key_0(sr_key_0),
        .sr_vld_0(sr_vld_0), .sr_hit_0(sr_hit_0), .sr_dout_0(sr_dout_0),
        .update_1(update_1), .up_key_1(up_key_1), .up_din_1(up_din_1),
        .up_del_1(up_del_1), .up_bp_1(up_bp_1),
`ifdef ZT_CUCKOO_ARB_STATS_EN
        .st_srch(st_srch), .st_upd(st_upd), .st_bp(st_bp),
`endif
        .err(err)
    );

    // Clock and cycle index
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Table model: one-cycle search latency, hit = key[0], dout = key[1]
    logic tbl_vld_q = 1'b0;
    logic [KW-1:0] tbl_key_q = '0;
    logic inj_vld = 1'b0;
    always @(posedge clk) begin
        tbl_vld_q <= search_0;
        tbl_key_q <= sr_key_0;
    end
    assign sr_vld_0  = tbl_vld_q | inj_vld;
    assign sr_hit_0  = tbl_key_q[0];
    assign sr_dout_0 = tbl_key_q[1];

    logic [KW-1:0] sk [NS];
    logic [KW-1:0] uk [NU];
    logic ud [NU];
    logic ul [NU];

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Expect requester id to win the search port this cycle; queue its routed response.
    task automatic exp_srch(input int id);
        chk("sgnt", 32'(sgnt), 32'(1 << id));
        chk("search_0", 32'(search_0), 32'd1);
        chk("sr_key_0", 32'(sr_key_0), 32'(sk[id]));
        exp_q.push_back({16'(cyc + 1), 4'(1 << id), sk[id][0], sk[id][1]});
    endtask

    task automatic exp_upd(input int id);
        chk("ugnt", 32'(ugnt), 32'(1 << id));
        chk("update_1", 32'(update_1), 32'd1);
        chk("up_key_1", 32'(up_key_1), 32'(uk[id]));
        chk("up_din_1", 32'(up_din_1), 32'(ud[id]));
        chk("up_del_1", 32'(up_del_1), 32'(ul[id]));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_sgnt"}, 32'(sgnt), 32'd0);
        chk({tag, "_ugnt"}, 32'(ugnt), 32'd0);
        chk({tag, "_search"}, 32'(search_0), 32'd0);
        chk({tag, "_update"}, 32'(update_1), 32'd0);
        chk({tag, "_srsp"}, 32'(srsp_vld), 32'd0);
    endtask

    // Scoreboard: compare routed responses against the expected queue, including arrival cycle.
    always @(negedge clk) begin
        if (rst && (srsp_vld != '0 || (exp_q.size() > 0 && exp_q[0][W-1:6] == cyc[15:0]))) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("srsp", 32'({cyc[15:0], srsp_vld, srsp_hit, srsp_dout}), 32'(exp_e));
        end
    end

    initial begin
        sk[0] = 5'h03; sk[1] = 5'h06; sk[2] = 5'h0F; sk[3] = 5'h1C;
        uk[0] = 5'h15; uk[1] = 5'h0A;
        ud[0] = 1'b1;  ud[1] = 1'b0;
        ul[0] = 1'b0;  ul[1] = 1'b1;
        skey = {sk[3], sk[2], sk[1], sk[0]};
        ukey = {uk[1], uk[0]};
        udin = {ud[1], ud[0]};
        udel = {ul[1], ul[0]};

        // Reset with requests pending: everything quiet
        ready = 1'b1; sreq = 4'hF; ureq = 2'b11;
        step(); mid();
        chk_quiet("rst");
        chk("rst_err", 32'(err), 32'd0);
        step(); rst = 1'b1; ureq = 2'b00;
        mid();
        chk_quiet("post_rst");

        // Full rotation, burst of 8, one drain cycle, resume at requester 0
        for (int i = 0; i < 8; i++) begin
            step(); mid(); exp_srch(i % 4);
        end
        step(); mid();
        chk("drain_search", 32'(search_0), 32'd0);
        chk("drain_sgnt", 32'(sgnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); mid(); exp_srch(i);
        end
        step(); sreq = '0; mid();
        chk("idle_search", 32'(search_0), 32'd0);

        // Sparse requesters 0 and 2, responses routed back
        step(); sreq = 4'b0101; mid(); exp_srch(0);
        step(); sreq = 4'b0100; mid(); exp_srch(2);
        step(); sreq = '0; mid();
        chk("t2_idle", 32'(search_0), 32'd0);

        // Update backpressure, then alternation
        step(); ureq = 2'b11; up_bp_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_ugnt", 32'(ugnt), 32'd0);
            chk("bp_update", 32'(update_1), 32'd0);
            step();
        end
        up_bp_1 = 1'b0; mid(); exp_upd(0);
        step(); mid(); exp_upd(1);
        step(); mid(); exp_upd(0);
`ifdef ZT_CUCKOO_ARB_STATS_EN
        chk("st_bp", st_bp, 32'd3);
        chk("st_upd", st_upd, 32'd2);
        chk("st_srch", st_srch, 32'd14);
`endif

        // Table not ready blocks both ports; then concurrent search and update
        step(); ready = 1'b0; sreq = 4'b0010; ureq = 2'b01; mid();
        chk("nrdy_sgnt", 32'(sgnt), 32'd0);
        chk("nrdy_ugnt", 32'(ugnt), 32'd0);
        step(); ready = 1'b1; mid(); exp_srch(1); exp_upd(0);
        step(); sreq = '0; ureq = '0; mid();
        chk("err_pre", 32'(err), 32'd0);

        // Unsolicited response sets sticky err
        step(); inj_vld = 1'b1; mid();
        chk("inj_srsp", 32'(srsp_vld), 32'd0);
        step(); inj_vld = 1'b0; mid();
        chk("err_set", 32'(err), 32'd1);
        repeat (3) step();
        mid();
        chk("err_sticky", 32'(err), 32'd1);

        // Reset mid-burst with a search outstanding
        step(); sreq = 4'hF; ureq = 2'b11; mid(); exp_srch(2); exp_upd(1);
        step(); mid(); exp_srch(3); exp_upd(0);
        step(); mid(); exp_srch(0); exp_upd(1);
        step(); rst = 1'b0; exp_q.delete(); #1;
        chk_quiet("mid_rst");
        chk("mid_rst_err", 32'(err), 32'd0);
        mid();
        chk("mid_rst_srsp2", 32'(srsp_vld), 32'd0);
        step(); rst = 1'b1; inj_vld = 1'b1; mid();
        chk_quiet("rel");
        chk("rel_err", 32'(err), 32'd0);
        step(); inj_vld = 1'b0; mid();
        chk("stale_err", 32'(err), 32'd1);
        exp_srch(0); exp_upd(0);
        step(); sreq = '0; ureq = '0;
        repeat (3) step();
        mid();
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
